// File: rtl/instr_sequencer_pkg.sv
// Shared types for the multi-cycle instruction sequencer.
package instr_sequencer_pkg;

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    LOAD      = 3'd3,
    STORE     = 3'd4,
    WRITEBACK = 3'd5
  } state_t;

  localparam int unsigned INSTRET_WIDTH_DEFAULT = 64;

  typedef logic [INSTRET_WIDTH_DEFAULT-1:0] instret_t;

  // States in which the sequencer owns an active bus request.
  function automatic logic is_bus_state(input state_t s);
    return (s == FETCH) || (s == LOAD) || (s == STORE);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Shared memory bus valid/ready handshake between the sequencer and the bus unit.
interface instr_sequencer_if;
  logic bus_valid;
  logic bus_ready;
  logic bus_is_data;

  modport master (output bus_valid, output bus_is_data, input bus_ready);
  modport slave  (input bus_valid, input bus_is_data, output bus_ready);
endinterface

// File: rtl/instr_sequencer_timeout.sv
// Bus wait watchdog: counts consecutive unaccepted request cycles and flags
// the cycle in which the wait reaches TIMEOUT_CYCLES.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic waiting,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count;

  assign expired = waiting && (count == CW'(TIMEOUT_CYCLES - 1));

  // The sequencer only leaves a bus state on accept or expiry, so clearing
  // whenever the request is not waiting also covers every state change.
  always_ff @(posedge clk) begin
    if (!reset_n || !waiting || expired) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: fetch / decode / execute / memory / writeback.
// Optional bus timeout abort is enabled by defining SEQUENCER_BUS_TIMEOUT_EN.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned INSTRET_WIDTH  = INSTRET_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     is_load,
  input  logic                     is_store,
  input  logic                     is_trap,
  input  logic                     is_mret,
  input  logic                     has_rd,
  input  logic                     irq,
  instr_sequencer_if.master        bus,
  output logic                     fetch_en,
  output logic                     decode_en,
  output logic                     execute_en,
  output logic                     load_en,
  output logic                     rd_en,
  output logic                     pc_en,
  output logic                     trap_take,
  output logic                     irq_take,
  output logic                     mret_take,
  output logic                     bus_error,
  output state_t                   state,
  output logic [INSTRET_WIDTH-1:0] instret
);

  logic valid;
  logic is_data;
  logic abort;
  logic timeout_hit;

  assign bus.bus_valid   = valid;
  assign bus.bus_is_data = is_data;
  assign bus_error       = timeout_hit;

`ifdef SEQUENCER_BUS_TIMEOUT_EN
  logic waiting;

  assign waiting = valid && !bus.bus_ready;

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .waiting (waiting),
    .expired (timeout_hit)
  );
`else
  logic unused_cfg;

  assign timeout_hit = 1'b0;
  assign unused_cfg  = (TIMEOUT_CYCLES != 0);
`endif

  // Decode datapath enables and bus request from the current state; all forced low in reset.
  always_comb begin
    valid      = 1'b0;
    is_data    = 1'b0;
    fetch_en   = 1'b0;
    decode_en  = 1'b0;
    execute_en = 1'b0;
    load_en    = 1'b0;
    rd_en      = 1'b0;
    pc_en      = 1'b0;
    trap_take  = 1'b0;
    irq_take   = 1'b0;
    mret_take  = 1'b0;
    if (reset_n) begin
      valid = is_bus_state(state);
      unique case (state)
        FETCH:     fetch_en = bus.bus_ready;
        DECODE:    decode_en = 1'b1;
        EXECUTE:   execute_en = 1'b1;
        LOAD: begin
          is_data = 1'b1;
          load_en = bus.bus_ready;
        end
        STORE:     is_data = 1'b1;
        WRITEBACK: begin
          pc_en = 1'b1;
          if (abort || is_trap) begin
            trap_take = 1'b1;
          end else if (is_mret) begin
            mret_take = 1'b1;
          end else if (irq) begin
            irq_take = 1'b1;
            rd_en    = has_rd;
          end else begin
            rd_en = has_rd;
          end
        end
        default: ;
      endcase
    end
  end

  // State sequencing, abort latch and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= FETCH;
      instret <= '0;
      abort   <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (bus.bus_ready) begin
            state <= DECODE;
          end else if (timeout_hit) begin
            abort <= 1'b1;
            state <= WRITEBACK;
          end
        end
        DECODE: state <= EXECUTE;
        EXECUTE: begin
          if (is_load) begin
            state <= LOAD;
          end else if (is_store) begin
            state <= STORE;
          end else begin
            state <= WRITEBACK;
          end
        end
        LOAD, STORE: begin
          if (bus.bus_ready) begin
            state <= WRITEBACK;
          end else if (timeout_hit) begin
            abort <= 1'b1;
            state <= WRITEBACK;
          end
        end
        WRITEBACK: begin
          state <= FETCH;
          abort <= 1'b0;
          if (!abort && !is_trap) begin
            instret <= instret + INSTRET_WIDTH'(1);
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
Multi-cycle control FSM for the non-pipelined core. It sequences fetch, decode, execute, memory access and writeback around the decoder, ALU and register file. It owns the shared memory bus valid/ready handshake, retires instructions, raises trap/interrupt entry, and counts retired instructions.
Sits between the core's bus interface and the datapath enables. Consumes decoder flags from the instruction register.

Parameters:
TIMEOUT_CYCLES, 64, bus wait cycles before abort (used only with the optional feature)
INSTRET_WIDTH, 64, width of retired-instruction counter

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous active-low reset
is_load  in  1  decoded instr is LOAD
is_store  in  1  decoded instr is STORE
is_trap  in  1  decoded ECALL/EBREAK
is_mret  in  1  decoded MRET
has_rd  in  1  decoded instr writes rd
irq  in  1  level interrupt request, already masked by CSR enable
bus_ready  in  1  memory handshake accept
bus_valid  out  1  memory request active
bus_is_data  out  1  1 = load/store access, 0 = fetch
fetch_en  out  1  latch instruction register
decode_en  out  1  latch register-file operands
execute_en  out  1  latch ALU result / branch target
load_en  out  1  latch load data
rd_en  out  1  register-file write strobe
pc_en  out  1  update PC
trap_take  out  1  enter trap handler this cycle
irq_take  out  1  enter interrupt handler this cycle
mret_take  out  1  return from handler this cycle
bus_error  out  1  bus timeout abort pulse
state  out  3  current state_t (debug)
instret  out  INSTRET_WIDTH  retired-instruction count

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset_n` is synchronous and active-low.
- Reset: state <= FETCH, instret <= 0, timeout counter <= 0. While reset_n==0, every output except state and instret is forced to 0.
- States: FETCH, DECODE, EXECUTE, LOAD, STORE, WRITEBACK.
- FETCH:
  - bus_valid=1, bus_is_data=0.
  - On bus_ready: fetch_en=1, go to DECODE. Otherwise stay.
- DECODE: decode_en=1, go to EXECUTE. Exactly one cycle.
- EXECUTE: execute_en=1. Next state:
  - is_load -> LOAD.
  - is_store -> STORE.
  - otherwise -> WRITEBACK.
  - Flags are sampled in this cycle only. If is_load and is_store are both set, is_load wins.
- LOAD:
  - bus_valid=1, bus_is_data=1.
  - On bus_ready: load_en=1, go to WRITEBACK.
- STORE:
  - bus_valid=1, bus_is_data=1.
  - On bus_ready: go to WRITEBACK.
- WRITEBACK: single cycle, pc_en=1, then always -> FETCH. Priority, highest first:
  1. bus abort latched: trap_take=1, rd_en=0.
  2. is_trap: trap_take=1, rd_en=0.
  3. is_mret: mret_take=1, rd_en=0.
  4. irq: irq_take=1, rd_en=has_rd. The current instruction completes before entry.
  5. Otherwise: rd_en=has_rd.
- instret increments by 1 in every WRITEBACK cycle except aborted or trapped ones. Wraps modulo 2^INSTRET_WIDTH.
- Bus handshake:
  - bus_valid stays high until the cycle bus_ready is seen.
  - bus_ready while bus_valid==0 is ignored.
  - bus_is_data is stable while bus_valid is high.
- Latency with zero-wait bus:
  - ALU/branch/jump: 4 cycles.
  - Load/store: 5 cycles.
  - Each bus wait cycle adds 1.
- irq arriving mid-instruction is not sampled until WRITEBACK. irq in the same WRITEBACK cycle as is_trap: trap wins, and irq is re-evaluated at the next WRITEBACK.
- Reset asserted in any state, including mid bus wait: next state FETCH, bus_valid drops during the reset cycle.

Optional Feature:
Macro SEQUENCER_BUS_TIMEOUT_EN.
- Defined:
  - A counter increments each cycle with bus_valid=1 && bus_ready=0, and clears on accept or state change.
  - When it reaches TIMEOUT_CYCLES-1 with no ready: bus_error pulses for one cycle, the abort flag is latched, and the FSM goes to WRITEBACK.
  - WRITEBACK then follows the abort rule (trap_take=1, no rd write, no instret increment).
  - The abort flag clears on entering FETCH.
- Undefined: no counter, bus_error tied 0, bus waits indefinitely.

Decomposition:
- Types_pkg: add state_t enum (FETCH=0, DECODE, EXECUTE, LOAD, STORE, WRITEBACK, 3-bit).
- Types_pkg: add instret_t.
- No new constants needed in Opcodes_pkg.
- One sub-module is natural: bus_timeout_counter (counter + compare, instantiated only under the macro).
- FSM, output decode and instret stay in instr_sequencer.

Test Plan:
- Reset, then ADD (has_rd=1) with bus_ready always 1 -> states FETCH, DECODE, EXECUTE, WRITEBACK, FETCH; rd_en=1 in cycle 4; instret=1.
- LOAD with 3 wait cycles in LOAD -> bus_valid=1, bus_is_data=1 for 4 cycles; load_en on the 4th; total 8 cycles; instret+1.
- STORE (has_rd=0) followed by ECALL -> store gives rd_en=0 and instret=1. ECALL gives trap_take=1 in its WRITEBACK, rd_en=0, instret stays 1.
- irq raised during DECODE of an ADDI -> irq_take=1 and rd_en=1 in the same WRITEBACK; instret increments; next state FETCH.
- reset_n low during the 2nd wait cycle of FETCH -> bus_valid=0 that cycle; state=FETCH and instret=0 after.
- With SEQUENCER_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, bus_ready never asserted in LOAD -> bus_error pulses on the 8th wait cycle; WRITEBACK has trap_take=1 and rd_en=0; instret unchanged.
